// File: rtl/randomizer_par.sv
// W-bit-per-clock 802.16 PRBS randomizer (1 + x^14 + x^15) with ready/valid flow control,
// per-burst seed reload, loadable seed register and burst bit counter. Optional RANDPAR_BYPASS_EN.
module randomizer_par #(
    parameter int          W            = 8,
    parameter logic [14:0] DEFAULT_SEED = 15'b100101010000000,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     in_bits,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [W-1:0]     out_bits,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    input  logic [14:0]      seed_in,
    input  logic             seed_load,
    output logic             seed_err,
    input  logic             restart,
`ifdef RANDPAR_BYPASS_EN
    input  logic             bypass,
`endif
    output logic [CNT_W-1:0] burst_bits
);

    // Handshake: a beat moves when valid && ready on the same rising edge; the output
    // register is refilled in the same cycle it drains, so in_ready only looks at out_ready.

    localparam int SUM_W = ((CNT_W > 7) ? CNT_W : 7) + 1;

    logic [14:0]      lfsr;
    logic [14:0]      seed_reg;
    logic [14:0]      base_state;
    logic [14:0]      adv_state;
    logic [14:0]      lfsr_next;
    logic [W-1:0]     scr_bits;
    logic [W-1:0]     beat_bits;
    logic             accept;
    logic             byp;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;
    logic [SUM_W-1:0] cnt_sum;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef RANDPAR_BYPASS_EN
    assign byp = bypass;
`else
    assign byp = 1'b0;
`endif

    // restart takes effect in the same cycle, so a coincident beat starts the new burst
    assign base_state = restart ? seed_reg : lfsr;

    always_comb begin : scramble
        logic [14:0] v;
        logic        p;
        v        = base_state;
        p        = 1'b0;
        scr_bits = '0;
        for (int i = 0; i < W; i++) begin
            p           = v[13] ^ v[14];
            scr_bits[i] = in_bits[i] ^ p;
            v           = {v[13:0], p};
        end
        adv_state = v;
    end

    assign beat_bits = byp ? in_bits : scr_bits;

    always_comb begin
        lfsr_next = base_state;
        if (accept) begin
            if (in_last) begin
                lfsr_next = seed_reg;
            end else if (!byp) begin
                lfsr_next = adv_state;
            end
        end
    end

    assign cnt_base = restart ? '0 : burst_bits;
    assign cnt_sum  = SUM_W'(cnt_base) + SUM_W'(W);

    always_comb begin
        cnt_next = cnt_base;
        if (accept) begin
            if (in_last) begin
                cnt_next = '0;
            end else if (cnt_sum > SUM_W'({CNT_W{1'b1}})) begin
                cnt_next = {CNT_W{1'b1}};
            end else begin
                cnt_next = cnt_sum[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr       <= DEFAULT_SEED;
            seed_reg   <= DEFAULT_SEED;
            out_bits   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            seed_err   <= 1'b0;
            burst_bits <= '0;
        end else begin
            lfsr       <= lfsr_next;
            burst_bits <= cnt_next;
            seed_err   <= seed_load && (seed_in == 15'd0);
            // the reload above already sampled the old seed_reg this cycle
            if (seed_load && (seed_in != 15'd0)) begin
                seed_reg <= seed_in;
            end
            if (accept) begin
                out_bits  <= beat_bits;
                out_last  <= in_last;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_randomizer_par.sv
// Self-checking bench for randomizer_par (W=8): directed steps followed by random traffic,
// compared against a keystream model built from the PRBS recurrence h[n] = h[n-15] ^ h[n-14].
module tb_randomizer_par;

    localparam logic [14:0] DEF_SEED = 15'b100101010000000;

    logic        clk;
    logic        reset;
    logic [7:0]  in_bits;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  out_bits;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic [14:0] seed_in;
    logic        seed_load;
    logic        seed_err;
    logic        restart;
    logic        bypass_s;
    logic [15:0] burst_bits;

    randomizer_par #(.W(8), .DEFAULT_SEED(DEF_SEED), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_bits    (in_bits),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_bits   (out_bits),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .seed_in    (seed_in),
        .seed_load  (seed_load),
        .seed_err   (seed_err),
        .restart    (restart),
`ifdef RANDPAR_BYPASS_EN
        .bypass     (bypass_s),
`endif
        .burst_bits (burst_bits)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_tests = 0;
    int          n_fail  = 0;

    // reference model state: which seed started the current burst and how many bits used
    logic [14:0] m_seed;
    logic [14:0] m_bseed;
    int          m_off;
    int          m_cnt;
    logic        m_ov;
    logic        m_olast;
    logic        m_serr;
    logic [7:0]  m_obits;
    logic [7:0]  first_out;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // keystream bits off..off+7 of the sequence seeded by seed (oldest register bit first)
    function automatic logic [7:0] ks(input logic [14:0] seed, input int off);
        bit         h [0:1100];
        logic [7:0] r;
        for (int j = 0; j < 15; j++) h[j] = seed[14-j];
        for (int n = 15; n < 15 + off + 8; n++) h[n] = h[n-15] ^ h[n-14];
        for (int k = 0; k < 8; k++) r[k] = h[15+off+k];
        return r;
    endfunction

    task automatic model_reset();
        m_seed  = DEF_SEED;
        m_bseed = DEF_SEED;
        m_off   = 0;
        m_cnt   = 0;
        m_ov    = 1'b0;
        m_olast = 1'b0;
        m_serr  = 1'b0;
        m_obits = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_async_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk("rst_out_bits", out_bits, 8'h00);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_seed_err", seed_err, 1'b0);
        chk("rst_burst_bits", burst_bits, 16'd0);
        chk("rst_in_ready", in_ready, 1'b1);
    endtask

    // one clock: drive inputs, check in_ready, clock, advance model, check registered outputs
    task automatic step(input logic v, input logic [7:0] d, input logic l, input logic ordy,
                        input logic rs, input logic sl, input logic [14:0] si);
        logic acc;
        in_valid  = v;
        in_bits   = d;
        in_last   = l;
        out_ready = ordy;
        restart   = rs;
        seed_load = sl;
        seed_in   = si;
        #1;
        chk("in_ready", in_ready, !m_ov || ordy);
        acc = v && (!m_ov || ordy);
        @(posedge clk);
        #1;
        if (rs) begin
            m_off   = 0;
            m_bseed = m_seed;
            m_cnt   = 0;
        end
        if (acc) begin
            m_obits = bypass_s ? d : (d ^ ks(m_bseed, m_off));
            m_olast = l;
            m_ov    = 1'b1;
            if (l) begin
                m_off   = 0;
                m_bseed = m_seed;
                m_cnt   = 0;
            end else begin
                if (!bypass_s) m_off = m_off + 8;
                m_cnt = (m_cnt + 8 > 65535) ? 65535 : m_cnt + 8;
            end
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        m_serr = sl && (si == 15'd0);
        if (sl && si != 15'd0) m_seed = si;
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("out_bits", out_bits, m_obits);
            chk("out_last", out_last, m_olast);
        end
        chk("burst_bits", burst_bits, m_cnt);
        chk("seed_err", seed_err, m_serr);
    endtask

    initial begin
        reset     = 1'b1;
        in_bits   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        seed_in   = '0;
        seed_load = 1'b0;
        restart   = 1'b0;
        bypass_s  = 1'b0;
        do_reset();

        // seed 4000 then restart: two zero beats give 01, C0
        step(0, 8'h00, 0, 1, 0, 1, 15'h4000);
        step(0, 8'h00, 0, 1, 1, 0, 15'h0000);
        step(1, 8'h00, 0, 1, 0, 0, 15'h0000);
        chk("tp1_beat0", out_bits, 8'h01);
        step(1, 8'h00, 0, 1, 0, 0, 15'h0000);
        chk("tp1_beat1", out_bits, 8'hC0);
        chk("tp1_bits16", burst_bits, 16'd16);

        // 3-beat burst (restart on beat 1), then a 4th beat restarts the sequence
        step(1, 8'h00, 0, 1, 1, 0, 15'h0000);
        first_out = out_bits;
        chk("tp2_bits8", burst_bits, 16'd8);
        step(1, 8'h00, 0, 1, 0, 0, 15'h0000);
        step(1, 8'h00, 1, 1, 0, 0, 15'h0000);
        chk("tp2_last_bits0", burst_bits, 16'd0);
        step(1, 8'h00, 0, 1, 0, 0, 15'h0000);
        chk("tp2_reload", out_bits, first_out);

        // backpressure: five stalled cycles with a beat offered
        step(1, 8'h5A, 0, 1, 0, 0, 15'h0000);
        for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0, 0, 0, 0, 15'h0000);
        for (int i = 0; i < 4; i++) step(1, 8'($urandom), 0, 1, 0, 0, 15'h0000);
        step(1, 8'h00, 1, 1, 0, 0, 15'h0000);

        // zero seed rejected; seed load coincident with in_last uses old seed
        step(0, 8'h00, 0, 1, 0, 1, 15'h1234);
        step(0, 8'h00, 0, 1, 1, 0, 15'h0000);
        step(1, 8'h00, 0, 1, 0, 0, 15'h0000);
        step(0, 8'h00, 0, 1, 0, 1, 15'h0000);
        chk("tp4_seed_err_pulse", seed_err, 1'b1);
        step(1, 8'h00, 1, 1, 0, 1, 15'h4000);
        chk("tp4_seed_err_clear", seed_err, 1'b0);
        step(1, 8'h00, 0, 1, 0, 0, 15'h0000);
        chk("tp4_old_seed", out_bits, ks(15'h1234, 0));
        step(1, 8'h00, 1, 1, 0, 0, 15'h0000);
        step(1, 8'h00, 0, 1, 0, 0, 15'h0000);
        chk("tp4_new_seed", out_bits, 8'h01);

        // reset mid-burst with a held output beat
        step(1, 8'h00, 0, 0, 0, 0, 15'h0000);
        in_valid = 1'b0;
        do_reset();
        step(1, 8'h00, 0, 1, 0, 0, 15'h0000);
        chk("tp5_default_seed", out_bits, ks(DEF_SEED, 0));

`ifdef RANDPAR_BYPASS_EN
        step(1, 8'h00, 0, 1, 0, 1, 15'h4000);
        step(1, 8'h00, 0, 1, 1, 0, 15'h0000);
        chk("byp_beat0", out_bits, 8'h01);
        bypass_s = 1'b1;
        step(1, 8'h00, 0, 1, 0, 0, 15'h0000);
        chk("byp_beat1", out_bits, 8'h00);
        bypass_s = 1'b0;
        step(1, 8'h00, 1, 1, 0, 0, 15'h0000);
        chk("byp_beat2", out_bits, 8'hC0);
        chk("byp_bits", burst_bits, 16'd0);
`endif

        // counter saturation over a long burst
        in_valid  = 1'b1;
        in_bits   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        seed_load = 1'b0;
        restart   = 1'b1;
        for (int i = 1; i <= 8195; i++) begin
            @(posedge clk);
            #1;
            restart = 1'b0;
            if (i == 8191) chk("sat_pre", burst_bits, 16'd65528);
        end
        chk("sat_hold", burst_bits, 16'hFFFF);
        in_valid = 1'b0;
        restart  = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        chk("sat_restart", burst_bits, 16'd0);
        m_ov    = 1'b0;
        m_off   = 0;
        m_bseed = m_seed;
        m_cnt   = 0;
        m_serr  = 1'b0;

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic        v, l, ordy, rs, sl;
            logic [14:0] si;
            v    = ($urandom_range(0, 3) != 0);
            l    = ($urandom_range(0, 7) == 0) || (m_off >= 1000);
            ordy = ($urandom_range(0, 3) != 0);
            rs   = ($urandom_range(0, 19) == 0);
            sl   = ($urandom_range(0, 15) == 0);
            si   = ($urandom_range(0, 3) == 0) ? 15'd0 : 15'($urandom);
            step(v, 8'($urandom), l, ordy, rs, sl, si);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/randomizer_par.md
# randomizer_par

Parametrised W-bit-per-clock 802.16 PRBS randomizer (generator 1 + x^14 + x^15) for the transmit chain between the MAC burst interface and the FEC encoder. It adds ready/valid flow control and burst framing with automatic per-burst seed reload. It also provides a runtime-loadable seed register and a saturating per-burst bit counter, so one instance serves any datapath width.

## Interface
- W, 8: bits processed per clock, 1..64; bit 0 of a beat is first in time
- DEFAULT_SEED, 15'b100101010000000: reset value of LFSR and seed register
- CNT_W, 16: width of the burst bit counter
- clk  in  1  clock, all state on posedge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- in_bits  in  W  data beat
- in_valid  in  1  beat offered
- in_last  in  1  beat is final beat of burst
- in_ready  out  1  beat accepted when in_valid && in_ready
- out_bits  out  W  randomized beat (registered)
- out_valid  out  1  output beat held
- out_last  out  1  copy of in_last for that beat
- out_ready  in  1  downstream accepts when out_valid && out_ready
- seed_in  in  15  new seed
- seed_load  in  1  write seed_in into seed register
- seed_err  out  1  one-cycle pulse: zero seed rejected
- restart  in  1  reload LFSR from seed register immediately
- burst_bits  out  CNT_W  bits accepted in current burst, saturating

## Operation
- Per bit i = 0..W-1 in order: p = v[13]^v[14]; out[i] = in[i]^p; v = {v[13:0], p}. Unrolled combinationally; LFSR advances exactly W steps per accepted beat.
- Single output register stage: in_ready = !out_valid || out_ready. Accepted beat loads out_bits/out_last, sets out_valid. out_valid clears on out_ready without a new beat. Output held stable while out_valid && !out_ready.
- Seed register: seed_load with seed_in != 0 writes it. seed_in == 0 leaves it unchanged and pulses seed_err next cycle. Writing the seed never disturbs the running LFSR.
- Accepted beat with in_last: after that beat, LFSR <= seed register. burst_bits <= 0.
- restart: LFSR uses seed register value this cycle. burst_bits restarts from 0. A beat accepted in the same cycle is scrambled from the freshly loaded seed, i.e. it is the first beat of a new burst.
- Simultaneous seed_load and end-of-burst reload, or restart: the old seed register value is used. The new seed applies to the following reload.
- burst_bits adds W per accepted non-last beat. It saturates at 2^CNT_W-1.

## Timing
- Reset values: out_bits=0, out_valid=0, out_last=0, seed_err=0, burst_bits=0, LFSR=seed register=DEFAULT_SEED. in_ready=1 after reset.
- Latency: 1 clock from accepted input beat to out_valid.
- Throughput: one beat per clock while out_ready is held high.
- Reset mid-burst: output beat discarded, burst state lost, next beat treated as burst start.
- No combinational path from in_* to out_*. in_ready depends combinationally on out_ready only.

## Configuration
- RANDPAR_BYPASS_EN defined: adds input port bypass (1 bit). On an accepted beat with bypass=1: out_bits = in_bits, LFSR does not advance, burst_bits still counts. in_last and restart behave normally.
- RANDPAR_BYPASS_EN undefined: no bypass port; every beat is randomized.

## Test plan
- W=8, seed_load 15'h4000, restart, two zero beats, out_ready=1 -> out_bits 8'h01 then 8'hC0, each one clock after acceptance.
- W=8, 3-beat burst with in_last on beat 3, then a 4th zero beat -> 4th output equals first output of the burst (auto reload); burst_bits 0,8,16 then 0.
- out_ready low 5 cycles with in_valid high -> in_ready=0, out_bits frozen, LFSR state unchanged; resume -> continuous sequence with no bit lost or duplicated.
- seed_load with seed_in=0 -> seed_err pulse 1 cycle, next burst uses previous seed; seed_load 15'h4000 coincident with in_last -> current reload uses old seed, following burst starts 8'h01.
- Assert reset mid-burst with out_valid=1 -> out_valid=0 immediately (asynchronous); next burst scrambled from DEFAULT_SEED.
- RANDPAR_BYPASS_EN, bypass=1 on beat 2 of 3 zero beats -> outputs 8'h01, 8'h00, 8'hC0.
